// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: ALU opcodes,
// instruction opcode/funct constants and the controller state type.
package mc_ctrl_fsm_pkg;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t ALU_AND     = 3'b000;
   localparam alu_op_t ALU_OR      = 3'b001;
   localparam alu_op_t ALU_ADD     = 3'b010;
   localparam alu_op_t ALU_SUB     = 3'b110;
   localparam alu_op_t ALU_DEFAULT = 3'b011;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_R_EXEC,
      S_R_WB,
      S_MADDR,
      S_MREAD,
      S_MWB,
      S_MWRITE,
      S_BRANCH,
      S_JUMP
   } state_t;

   // States that stall on the memory ready handshake.
   function automatic logic is_wait_state(state_t s);
      return (s == S_FETCH) || (s == S_MREAD) || (s == S_MWRITE);
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// datapath mux selects and strobes out.
interface mc_ctrl_fsm_if;
   import mc_ctrl_fsm_pkg::*;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   alu_op_t    alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic       pc_en;
   logic       iord;
   logic       mem_rd;
   logic       mem_wr;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord,
             mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg, reg_write
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord,
             mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg, reg_write
   );

endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct -> ALU operation decoder; valid_o low flags an unsupported funct.
module mc_alu_dec
   import mc_ctrl_fsm_pkg::*;
(
   input  logic [5:0] funct_i,
   output alu_op_t    alu_op_o,
   output logic       valid_o
);

   // Pure lookup; unknown functs fall back to the idle ALU code.
   always_comb begin
      alu_op_o = ALU_DEFAULT;
      valid_o  = 1'b1;
      case (funct_i)
         FN_ADD:  alu_op_o = ALU_ADD;
         FN_SUB:  alu_op_o = ALU_SUB;
         FN_AND:  alu_op_o = ALU_AND;
         FN_OR:   alu_op_o = ALU_OR;
         default: valid_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit: instruction sequencing, datapath
// control decode, memory-wait timeout and retired-instruction count.
//
//  state    | meaning
//  S_IDLE   | reset / post-timeout bubble, no strobes
//  S_FETCH  | read instruction at PC, PC+4; waits on mem_ready
//  S_DECODE | latch opcode/funct, precompute branch target
//  S_R_EXEC | R-type ALU operation rs op rt
//  S_R_WB   | write ALUOut to rd, retire
//  S_MADDR  | effective address rs + sext(imm)
//  S_MREAD  | load data read; waits on mem_ready
//  S_MWB    | write MDR to rt, retire
//  S_MWRITE | store data write; waits on mem_ready, retires on ready
//  S_BRANCH | beq compare, PC <= target when zero, retire
//  S_JUMP   | PC <= jump target, retire
module mc_ctrl_fsm
   import mc_ctrl_fsm_pkg::*;
#(
   parameter int RET_W    = 32,
   parameter int WAIT_MAX = 15
)(
   input  logic             clk,
   input  logic             rst_n,
   mc_ctrl_fsm_if.master    bus,
   output logic             illegal_o,
   output logic             timeout_o,
   output logic [RET_W-1:0] retired_o
);

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [5:0]       funct_q, funct_d;
   logic [7:0]       wait_q, wait_d;
   logic             timeout_q, timeout_d;
   logic [RET_W-1:0] retired_q, retired_d;
   logic             retire;
   logic             pc_write;
   logic [5:0]       dec_funct;
   alu_op_t          dec_alu_op;
   logic             dec_valid;

   // Decode the live funct while deciding legality, the latched one afterwards.
   assign dec_funct = (state_q == S_DECODE) ? bus.funct : funct_q;

   mc_alu_dec u_alu_dec (
      .funct_i  (dec_funct),
      .alu_op_o (dec_alu_op),
      .valid_o  (dec_valid)
   );

   // State and bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         funct_q   <= '0;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         funct_q   <= funct_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         retired_q <= retired_d;
      end
   end

   // Next state, instruction latch, wait timeout and retire count.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      funct_d   = funct_q;
      wait_d    = '0;
      timeout_d = timeout_q;
      retired_d = retired_q;
      retire    = 1'b0;
      illegal_o = 1'b0;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d    = bus.opcode;
            funct_d = bus.funct;
            case (bus.opcode)
               OP_RTYPE: begin
                  if (dec_valid) state_d = S_R_EXEC;
                  else begin
                     illegal_o = 1'b1;
                     state_d   = S_FETCH;
                  end
               end
               OP_LW, OP_SW: state_d = S_MADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_o = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         S_R_EXEC: state_d = S_R_WB;
         S_R_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MADDR:  state_d = (op_q == OP_SW) ? S_MWRITE : S_MREAD;
         S_MREAD:  if (bus.mem_ready) state_d = S_MWB;
         S_MWB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MWRITE: begin
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_BRANCH, S_JUMP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default:  state_d = S_IDLE;
      endcase

      // A stalled access that hits the limit abandons the instruction.
      if (is_wait_state(state_q) && !bus.mem_ready) begin
         if (wait_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end

      if (retire) retired_d = retired_q + RET_W'(1);
   end

   // Moore datapath controls; ir_write/pc_en qualify on the fetch handshake.
   always_comb begin
      bus.alu_op     = ALU_DEFAULT;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'd0;
      bus.pc_src     = 2'd0;
      bus.iord       = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      pc_write       = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.mem_rd    = 1'b1;
            bus.alu_src_b = 2'd1;
            bus.alu_op    = ALU_ADD;
            bus.ir_write  = bus.mem_ready;
            pc_write      = bus.mem_ready;
         end
         S_DECODE: begin
            bus.alu_src_b = 2'd3;
            bus.alu_op    = ALU_ADD;
         end
         S_R_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = dec_alu_op;
         end
         S_R_WB: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
         end
         S_MADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            bus.alu_op    = ALU_ADD;
         end
         S_MREAD: begin
            bus.iord   = 1'b1;
            bus.mem_rd = 1'b1;
         end
         S_MWB: begin
            bus.mem_to_reg = 1'b1;
            bus.reg_write  = 1'b1;
         end
         S_MWRITE: begin
            bus.iord   = 1'b1;
            bus.mem_wr = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_SUB;
            bus.pc_src    = 2'd1;
         end
         S_JUMP: begin
            bus.pc_src = 2'd2;
            pc_write   = 1'b1;
         end
         default: ;
      endcase
      bus.pc_en = pc_write | ((state_q == S_BRANCH) & bus.zero);
   end

   assign timeout_o = timeout_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm. Control outputs are packed into one vector
// {alu_op, src_a, src_b, pc_src, pc_en, iord, mem_rd, mem_wr, ir_write,
//  reg_dst, mem_to_reg, reg_write} and compared against hand-built constants.
module tb_mc_ctrl_fsm;
   import mc_ctrl_fsm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        illegal;
   logic        timeout;
   logic [31:0] retired;
   logic [15:0] ctl;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_ret = '0;

   always #5 clk = ~clk;

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(.RET_W(32), .WAIT_MAX(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .illegal_o (illegal),
      .timeout_o (timeout),
      .retired_o (retired)
   );

   assign ctl = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                 bus.pc_en, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_write,
                 bus.reg_dst, bus.mem_to_reg, bus.reg_write};

   localparam logic [15:0] C_IDLE       = {ALU_DEFAULT, 1'b0, 2'd0, 2'd0, 8'b0000_0000};
   localparam logic [15:0] C_FETCH_RDY  = {ALU_ADD,     1'b0, 2'd1, 2'd0, 8'b1010_1000};
   localparam logic [15:0] C_FETCH_WAIT = {ALU_ADD,     1'b0, 2'd1, 2'd0, 8'b0010_0000};
   localparam logic [15:0] C_DECODE     = {ALU_ADD,     1'b0, 2'd3, 2'd0, 8'b0000_0000};
   localparam logic [15:0] C_R_WB       = {ALU_DEFAULT, 1'b0, 2'd0, 2'd0, 8'b0000_0101};
   localparam logic [15:0] C_MADDR      = {ALU_ADD,     1'b1, 2'd2, 2'd0, 8'b0000_0000};
   localparam logic [15:0] C_MREAD      = {ALU_DEFAULT, 1'b0, 2'd0, 2'd0, 8'b0110_0000};
   localparam logic [15:0] C_MWB        = {ALU_DEFAULT, 1'b0, 2'd0, 2'd0, 8'b0000_0011};
   localparam logic [15:0] C_MWRITE     = {ALU_DEFAULT, 1'b0, 2'd0, 2'd0, 8'b0101_0000};
   localparam logic [15:0] C_JUMP       = {ALU_DEFAULT, 1'b0, 2'd0, 2'd2, 8'b1000_0000};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({ctl, illegal, timeout} !== {C_IDLE, 2'b00}) begin
         n_err++;
         $display("FAIL reset_ctl: got %h/%b%b want %h/00", ctl, illegal, timeout, C_IDLE);
      end
      n_vec++;
      if (retired !== 32'd0) begin
         n_err++;
         $display("FAIL reset_retired: got %0d want 0", retired);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_IDLE) begin
         n_err++;
         $display("FAIL idle_cycle: got %h want %h", ctl, C_IDLE);
      end
      tick();
      n_vec++;
      if (ctl !== C_FETCH_RDY) begin
         n_err++;
         $display("FAIL first_fetch: got %h want %h", ctl, C_FETCH_RDY);
      end
   endtask

   task automatic test_rtype(input logic [5:0] fn, input alu_op_t exp_op);
      logic [15:0] exp_exec;
      exp_exec = {exp_op, 1'b1, 2'd0, 2'd0, 8'h00};
      bus.mem_ready = 1'b1; bus.opcode = OP_RTYPE; bus.funct = fn;
      tick();
      n_vec++;
      if ({ctl, illegal} !== {C_DECODE, 1'b0}) begin
         n_err++;
         $display("FAIL rtype_decode fn=%h: got %h/%b want %h/0", fn, ctl, illegal, C_DECODE);
      end
      tick();
      bus.funct = 6'h3F;
      #1;
      n_vec++;
      if (ctl !== exp_exec) begin
         n_err++;
         $display("FAIL rtype_exec fn=%h: got %h want %h", fn, ctl, exp_exec);
      end
      tick();
      n_vec++;
      if (ctl !== C_R_WB) begin
         n_err++;
         $display("FAIL rtype_wb fn=%h: got %h want %h", fn, ctl, C_R_WB);
      end
      tick();
      exp_ret++;
      n_vec++;
      if ({ctl, retired} !== {C_FETCH_RDY, exp_ret}) begin
         n_err++;
         $display("FAIL rtype_retire fn=%h: got %h/%0d want %h/%0d", fn, ctl, retired, C_FETCH_RDY, exp_ret);
      end
   endtask

   task automatic test_beq(input logic z);
      logic [15:0] exp_br;
      exp_br = {ALU_SUB, 1'b1, 2'd0, 2'd1, z, 7'b000_0000};
      bus.mem_ready = 1'b1; bus.opcode = OP_BEQ; bus.funct = 6'h3F;
      tick();
      tick();
      bus.zero = z;
      #1;
      n_vec++;
      if (ctl !== exp_br) begin
         n_err++;
         $display("FAIL beq_branch z=%b: got %h want %h", z, ctl, exp_br);
      end
      tick();
      bus.zero = 1'b0;
      exp_ret++;
      #1;
      n_vec++;
      if ({ctl, retired} !== {C_FETCH_RDY, exp_ret}) begin
         n_err++;
         $display("FAIL beq_retire z=%b: got %h/%0d want %h/%0d", z, ctl, retired, C_FETCH_RDY, exp_ret);
      end
   endtask

   task automatic test_jump;
      bus.mem_ready = 1'b1; bus.opcode = OP_J;
      tick();
      tick();
      n_vec++;
      if (ctl !== C_JUMP) begin
         n_err++;
         $display("FAIL jump_state: got %h want %h", ctl, C_JUMP);
      end
      tick();
      exp_ret++;
      n_vec++;
      if (retired !== exp_ret) begin
         n_err++;
         $display("FAIL jump_retire: got %0d want %0d", retired, exp_ret);
      end
   endtask

   task automatic test_lw(input int waits);
      int rd_cycles;
      rd_cycles = 0;
      bus.mem_ready = 1'b1; bus.opcode = OP_LW;
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      n_vec++;
      if (ctl !== C_MADDR) begin
         n_err++;
         $display("FAIL lw_maddr: got %h want %h", ctl, C_MADDR);
      end
      tick();
      for (int i = 0; i <= waits; i++) begin
         bus.mem_ready = (i == waits);
         #1;
         if (bus.mem_rd === 1'b1) rd_cycles++;
         n_vec++;
         if (ctl !== C_MREAD) begin
            n_err++;
            $display("FAIL lw_mread i=%0d: got %h want %h", i, ctl, C_MREAD);
         end
         if (i != waits) tick();
      end
      n_vec++;
      if (rd_cycles != waits + 1) begin
         n_err++;
         $display("FAIL lw_rd_cycles: got %0d want %0d", rd_cycles, waits + 1);
      end
      tick();
      n_vec++;
      if (ctl !== C_MWB) begin
         n_err++;
         $display("FAIL lw_mwb: got %h want %h", ctl, C_MWB);
      end
      tick();
      exp_ret++;
      n_vec++;
      if ({ctl, retired} !== {C_FETCH_RDY, exp_ret}) begin
         n_err++;
         $display("FAIL lw_retire: got %h/%0d want %h/%0d", ctl, retired, C_FETCH_RDY, exp_ret);
      end
   endtask

   task automatic test_sw(input int waits);
      bus.mem_ready = 1'b1; bus.opcode = OP_SW;
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      for (int i = 0; i <= waits; i++) begin
         bus.mem_ready = (i == waits);
         #1;
         n_vec++;
         if ({ctl, retired} !== {C_MWRITE, exp_ret}) begin
            n_err++;
            $display("FAIL sw_mwrite i=%0d: got %h/%0d want %h/%0d", i, ctl, retired, C_MWRITE, exp_ret);
         end
         if (i != waits) tick();
      end
      tick();
      exp_ret++;
      n_vec++;
      if ({ctl, retired} !== {C_FETCH_RDY, exp_ret}) begin
         n_err++;
         $display("FAIL sw_retire: got %h/%0d want %h/%0d", ctl, retired, C_FETCH_RDY, exp_ret);
      end
   endtask

   task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
      bus.mem_ready = 1'b1; bus.opcode = op; bus.funct = fn;
      tick();
      n_vec++;
      if ({ctl, illegal} !== {C_DECODE, 1'b1}) begin
         n_err++;
         $display("FAIL illegal_pulse op=%h fn=%h: got %h/%b want %h/1", op, fn, ctl, illegal, C_DECODE);
      end
      tick();
      n_vec++;
      if ({ctl, illegal, retired} !== {C_FETCH_RDY, 1'b0, exp_ret}) begin
         n_err++;
         $display("FAIL illegal_return op=%h: got %h/%b/%0d want %h/0/%0d", op, ctl, illegal, retired, C_FETCH_RDY, exp_ret);
      end
   endtask

   task automatic test_wait_boundary;
      for (int k = 0; k < 14; k++) begin
         bus.mem_ready = 1'b0;
         #1;
         n_vec++;
         if ({ctl, timeout} !== {C_FETCH_WAIT, 1'b0}) begin
            n_err++;
            $display("FAIL wait14 k=%0d: got %h/%b want %h/0", k, ctl, timeout, C_FETCH_WAIT);
         end
         tick();
      end
      bus.mem_ready = 1'b1; bus.opcode = OP_J;
      #1;
      n_vec++;
      if ({ctl, timeout} !== {C_FETCH_RDY, 1'b0}) begin
         n_err++;
         $display("FAIL wait14_ready: got %h/%b want %h/0", ctl, timeout, C_FETCH_RDY);
      end
      tick();
      tick();
      tick();
      exp_ret++;
      n_vec++;
      if ({timeout, retired} !== {1'b0, exp_ret}) begin
         n_err++;
         $display("FAIL wait14_retire: got %b/%0d want 0/%0d", timeout, retired, exp_ret);
      end
   endtask

   task automatic test_timeout;
      for (int k = 0; k < 15; k++) begin
         bus.mem_ready = 1'b0;
         #1;
         n_vec++;
         if ({ctl, timeout} !== {C_FETCH_WAIT, 1'b0}) begin
            n_err++;
            $display("FAIL tmo_wait k=%0d: got %h/%b want %h/0", k, ctl, timeout, C_FETCH_WAIT);
         end
         tick();
      end
      n_vec++;
      if ({ctl, timeout, retired} !== {C_IDLE, 1'b1, exp_ret}) begin
         n_err++;
         $display("FAIL tmo_idle: got %h/%b/%0d want %h/1/%0d", ctl, timeout, retired, C_IDLE, exp_ret);
      end
      tick();
      n_vec++;
      if ({ctl, timeout} !== {C_FETCH_WAIT, 1'b1}) begin
         n_err++;
         $display("FAIL tmo_sticky: got %h/%b want %h/1", ctl, timeout, C_FETCH_WAIT);
      end
   endtask

   task automatic test_reset_mid;
      bus.mem_ready = 1'b1; bus.opcode = OP_LW;
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      exp_ret = '0;
      n_vec++;
      if ({ctl, timeout, retired} !== {C_IDLE, 1'b0, exp_ret}) begin
         n_err++;
         $display("FAIL reset_mid: got %h/%b/%0d want %h/0/0", ctl, timeout, retired, C_IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      tick();
      n_vec++;
      if (ctl !== C_FETCH_RDY) begin
         n_err++;
         $display("FAIL reset_mid_fetch: got %h want %h", ctl, C_FETCH_RDY);
      end
   endtask

   initial begin
      test_reset();
      test_rtype(FN_ADD, ALU_ADD);
      test_rtype(FN_SUB, ALU_SUB);
      test_rtype(FN_AND, ALU_AND);
      test_rtype(FN_OR,  ALU_OR);
      test_beq(1'b1);
      test_beq(1'b0);
      test_jump();
      test_lw(3);
      test_lw(0);
      test_sw(2);
      test_illegal(6'h3F, 6'h20);
      test_illegal(OP_RTYPE, 6'h21);
      test_wait_boundary();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
